// File: rtl/elastic_pipe_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
// Build option: define ELASTIC_PIPE_OCCUPANCY_EN to add the occupancy counter.
package elastic_pipe_pkg;

    localparam int ELASTIC_PIPE_WIDTH_DEF = 8;
    localparam int ELASTIC_PIPE_DEPTH_DEF = 4;

    // Bits needed to count from 0 up to and including depth items.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : elastic_pipe_pkg

// File: rtl/elastic_stage.sv
// One slice of the elastic pipeline: a data register plus its valid bit.
// The top decides when the slice loads; the slice only applies load and flush.
module elastic_stage
    import elastic_pipe_pkg::*;
#(
    parameter int WIDTH = ELASTIC_PIPE_WIDTH_DEF
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // Next state: take the predecessor's item on load; flush only drops the valid bit.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = valid_i;
            data_d  = data_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    // Slice register with asynchronous clear of both valid and data.
    always_ff @(posedge clock_i or posedge reset_i) begin
        // NOTE: the data register is reset as well as the valid bit, so an empty pipe never shows X.
        if (reset_i) begin
            // NOTE: sequential state is only ever updated with non-blocking assignments.
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : elastic_stage

// File: rtl/elastic_pipe.sv
// Elastic register pipeline: DEPTH independently advancing stages with
// valid/ready on both ends, so bubbles collapse and backpressure propagates.
// Build option: ELASTIC_PIPE_OCCUPANCY_EN adds the registered occupancy_o port.
module elastic_pipe
    import elastic_pipe_pkg::*;
#(
    parameter int WIDTH = ELASTIC_PIPE_WIDTH_DEF,
    parameter int DEPTH = ELASTIC_PIPE_DEPTH_DEF
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    input  logic [WIDTH-1:0]            in_data_i,
    output logic                        in_ready_o,
    output logic                        out_valid_o,
    output logic [WIDTH-1:0]            out_data_o,
    input  logic                        out_ready_i
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy_o
`endif
);

    logic [DEPTH-1:0]            stage_valid;
    logic [DEPTH-1:0][WIDTH-1:0] stage_data;
    logic [DEPTH-1:0]            accept;
    logic [DEPTH-1:0]            leave;

    // Ready chain from the output end back to the input: a stage accepts when it
    // is empty or its item is moving on this cycle.
    always_comb begin
        leave            = '0;
        accept           = '0;
        leave[DEPTH-1]   = stage_valid[DEPTH-1] & out_ready_i;
        accept[DEPTH-1]  = ~stage_valid[DEPTH-1] | leave[DEPTH-1];
        for (int k = DEPTH - 2; k >= 0; k--) begin
            leave[k]  = stage_valid[k] & accept[k + 1];
            accept[k] = ~stage_valid[k] | leave[k];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;

        if (k == 0) begin : g_head
            assign src_valid = in_valid_i;
            assign src_data  = in_data_i;
        end else begin : g_body
            assign src_valid = stage_valid[k - 1];
            assign src_data  = stage_data[k - 1];
        end

        elastic_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clock_i (clock_i),
            .reset_i (reset_i),
            .flush_i (flush_i),
            .load_i  (accept[k]),
            .valid_i (src_valid),
            .data_i  (src_data),
            .valid_o (stage_valid[k]),
            .data_o  (stage_data[k])
        );
    end

    assign in_ready_o  = accept[0];
    assign out_valid_o = stage_valid[DEPTH-1];
    assign out_data_o  = stage_data[DEPTH-1];

`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    localparam int OCC_W = occ_width(DEPTH);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             in_hs;
    logic             out_hs;

    assign in_hs  = in_valid_i & in_ready_o;
    assign out_hs = out_valid_o & out_ready_i;

    // Occupancy next state: flush empties; otherwise track net handshakes.
    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = '0;
        end else if (in_hs && !out_hs) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (out_hs && !in_hs) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy_o = occ_q;
`endif

endmodule : elastic_pipe
